sa_edge_feeder: RTL and testbench
=================================

Name: sa_edge_feeder

Overview:
- Edge injector for the weight-stationary systolic array.
- Drives the left-edge activation stream (ain/ain_slot/ain_val, one per row, skewed) and the top-edge weight stream (bin/bin_slot/bin_val, one per column).
- Manages the two weight banks per PE: loads the shadow bank while activations stream against the active bank, and swaps at weight-set boundaries.
- Sits between the tile buffers (valid/ready) and the PE grid.

Parameters:
- WIDTH, 4, operand width; matches PE WIDTH.
- N, 4, array dimension (rows = columns).
- DRAIN, 2*N, cycles a released bank stays write-protected after its last activation is accepted.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- w_valid  in  1  weight row beat valid
- w_ready  out  1  weight beat accepted when w_valid && w_ready
- w_data  in  N*WIDTH  one weight row; slice c goes to column c; rows presented bottom row (N-1) first
- x_valid  in  1  activation vector valid
- x_ready  out  1  activation accepted when x_valid && x_ready
- x_data  in  N*WIDTH  slice r goes to array row r
- x_last  in  1  final vector for the current weight set
- b_data  out  N*WIDTH  per-column bin
- b_slot  out  N  per-column bin_slot
- b_val  out  N  per-column bin_val
- a_data  out  N*WIDTH  per-row ain
- a_slot  out  N  per-row ain_slot
- a_val  out  N  per-row ain_val

Behaviour:
- Reset: all outputs 0; w_ready=1, x_ready=0; load_slot=0, act_slot=0, bank_full=2'b00, beat_cnt=0, drain_cnt=0; skew pipes cleared.
- Reset mid-operation discards partial loads and all in-flight data.
- Weight load:
  - w_ready = !bank_full[load_slot] && drain_cnt==0.
  - Accepted beat: next cycle b_val=all ones, b_data=w_data, b_slot=all load_slot. Otherwise b_val=0; b_data/b_slot hold.
  - beat_cnt counts 0..N-1. On beat N-1: bank_full[load_slot]<=1, load_slot toggles, beat_cnt<=0.
  - Beats may be non-consecutive. The PE column shifts only on bin_val, so gaps are harmless.
- Activation:
  - x_ready = bank_full[act_slot].
  - Accepted vector enters the skew pipe with slot=act_slot, val=1.
  - Row r output appears r+1 cycles after acceptance: row 0 is 1 register stage, row r is r+1 stages. Stage bubbles carry val=0 and data 0.
  - x_last accepted: bank_full[act_slot]<=0, act_slot toggles, drain_cnt<=DRAIN.
- drain_cnt decrements to 0 each cycle when nonzero. While nonzero, w_ready=0. This prevents a new load from overwriting a slot still read by in-flight skewed activations.
- Simultaneous events:
  - Final weight beat and x_last in the same cycle always target different banks; both updates apply.
  - Back-to-back weight sets stream without a bubble if the shadow bank is full when x_last is accepted.
- Empty: no loaded bank gives x_ready=0.
- Full: both banks full gives w_ready=0.
- Slot pointers are 1 bit and wrap naturally.

Optional Feature:
- Macro: SA_EDGE_FEEDER_PERF_EN.
- When defined, adds outputs:
  - perf_vec (32): accepted vectors.
  - perf_xstall (32): cycles with x_valid && !x_ready.
  - perf_wstall (32): cycles with w_valid && !w_ready.
- Counters saturate at all ones and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sa_pkg holds:
  - Default WIDTH and N.
  - typedef slot_t (1 bit).
  - typedef bank_state_t {EMPTY, FULL}.
  - Function drain_cycles(N) returning 2*N.
- Sub-module sa_skew_line (params WIDTH, DEPTH): a DEPTH-stage delay line carrying {data, slot, val}, instantiated per row with DEPTH=r+1 via a generate loop.

Test Plan:
1. Reset then idle: w_ready=1, x_ready=0, and all a_val/b_val stay 0 for 20 cycles.
2. Load 4 beats (rows 3,2,1,0 = 0x4444,0x3333,0x2222,0x1111), then 1 vector 0x4321 with x_last:
   - b_val=4'hF on the 4 cycles after each beat with b_slot=0.
   - x_ready rises the cycle after beat 4.
   - Rows 0..3 show a_data 1,2,3,4 at acceptance+1..+4, each with a_slot=0.
3. Double buffering: load set A, stream 3 vectors, load set B during streaming, stream with x_last on vector 3:
   - The next vector is accepted with no bubble and carries a_slot=1.
   - w_ready stays 0 for 8 cycles after x_last.
4. Both banks full: w_valid held high gives w_ready=0 and b_val=0 until x_last plus 8 drain cycles.
5. Gapped weight beats (w_valid toggling): 4 accepted beats over 9 cycles; bank_full asserts only after the 4th beat.
6. rst_n pulsed after 2 of 4 beats: after reset beat_cnt=0 and x_ready=0; 4 fresh beats are required before x_ready=1.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array edge feeder.
package sa_pkg;

    localparam int SA_WIDTH = 4;
    localparam int SA_N     = 4;

    typedef logic slot_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    function automatic int drain_cycles(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage delay line carrying {data, slot, val}; one instance per array row.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  slot_t            in_slot,
    input  logic             in_val,
    output logic [WIDTH-1:0] out_data,
    output slot_t            out_slot,
    output logic             out_val
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        slot_t            slot;
        logic             val;
    } stage_t;

    stage_t stage_q [DEPTH];
    stage_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = '{data: in_data, slot: in_slot, val: in_val};
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: every stage is reset, not just the valid bit, so a reset leaves no stale slot or data on the row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make all stages shift together on the same edge.
            stage_q <= stage_d;
        end
    end

    assign out_data = stage_q[DEPTH-1].data;
    assign out_slot = stage_q[DEPTH-1].slot;
    assign out_val  = stage_q[DEPTH-1].val;

endmodule

// File: rtl/sa_edge_feeder.sv
// Edge injector for the weight-stationary array: double-buffered weight load plus skewed activations.
// Optional performance counters are built when SA_EDGE_FEEDER_PERF_EN is defined.
module sa_edge_feeder
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int N     = SA_N,
    parameter int DRAIN = drain_cycles(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [N*WIDTH-1:0] w_data,
    input  logic               x_valid,
    output logic               x_ready,
    input  logic [N*WIDTH-1:0] x_data,
    input  logic               x_last,
    output logic [N*WIDTH-1:0] b_data,
    output logic [N-1:0]       b_slot,
    output logic [N-1:0]       b_val,
    output logic [N*WIDTH-1:0] a_data,
    output logic [N-1:0]       a_slot,
    output logic [N-1:0]       a_val
`ifdef SA_EDGE_FEEDER_PERF_EN
    ,
    output logic [31:0]        perf_vec,
    output logic [31:0]        perf_xstall,
    output logic [31:0]        perf_wstall
`endif
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = $clog2(DRAIN + 1);

    slot_t              load_slot_q, load_slot_d;
    slot_t              act_slot_q,  act_slot_d;
    bank_state_t        bank_q [2];
    bank_state_t        bank_d [2];
    logic [BW-1:0]      beat_cnt_q,  beat_cnt_d;
    logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
    logic [N*WIDTH-1:0] b_data_q,    b_data_d;
    logic [N-1:0]       b_slot_q,    b_slot_d;
    logic [N-1:0]       b_val_q,     b_val_d;

    logic w_fire;
    logic x_fire;

    // The drain window keeps a released bank intact until its skewed activations have left the grid.
    assign w_ready = (bank_q[load_slot_q] == EMPTY) && (drain_cnt_q == '0);
    assign x_ready = (bank_q[act_slot_q] == FULL);
    assign w_fire  = w_valid && w_ready;
    assign x_fire  = x_valid && x_ready;

    always_comb begin
        // NOTE: every variable gets a hold default first so no path infers a latch.
        load_slot_d = load_slot_q;
        act_slot_d  = act_slot_q;
        bank_d      = bank_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        b_data_d    = b_data_q;
        b_slot_d    = b_slot_q;
        b_val_d     = '0;

        if (drain_cnt_q != '0) begin
            drain_cnt_d = drain_cnt_q - 1'b1;
        end

        if (w_fire) begin
            b_val_d  = '1;
            b_data_d = w_data;
            b_slot_d = {N{load_slot_q}};
            if (beat_cnt_q == BW'(N - 1)) begin
                beat_cnt_d          = '0;
                bank_d[load_slot_q] = FULL;
                load_slot_d         = ~load_slot_q;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        // A final beat and x_last in one cycle always address opposite banks, so both updates stand.
        if (x_fire && x_last) begin
            bank_d[act_slot_q] = EMPTY;
            act_slot_d         = ~act_slot_q;
            drain_cnt_d        = DW'(DRAIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_slot_q <= 1'b0;
            act_slot_q  <= 1'b0;
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            b_data_q    <= '0;
            b_slot_q    <= '0;
            b_val_q     <= '0;
        end else begin
            load_slot_q <= load_slot_d;
            act_slot_q  <= act_slot_d;
            bank_q      <= bank_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            b_data_q    <= b_data_d;
            b_slot_q    <= b_slot_d;
            b_val_q     <= b_val_d;
        end
    end

    assign b_data = b_data_q;
    assign b_slot = b_slot_q;
    assign b_val  = b_val_q;

    for (genvar r = 0; r < N; r++) begin : g_row
        logic [WIDTH-1:0] row_data;
        slot_t            row_slot;

        // Bubbles enter as all-zero so idle stages carry neither data nor a slot tag.
        assign row_data = x_fire ? x_data[r*WIDTH +: WIDTH] : '0;
        assign row_slot = x_fire ? act_slot_q : 1'b0;

        sa_skew_line #(
            .WIDTH (WIDTH),
            .DEPTH (r + 1)
        ) u_skew (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_data  (row_data),
            .in_slot  (row_slot),
            .in_val   (x_fire),
            .out_data (a_data[r*WIDTH +: WIDTH]),
            .out_slot (a_slot[r]),
            .out_val  (a_val[r])
        );
    end

`ifdef SA_EDGE_FEEDER_PERF_EN
    logic [31:0] perf_vec_q,    perf_vec_d;
    logic [31:0] perf_xstall_q, perf_xstall_d;
    logic [31:0] perf_wstall_q, perf_wstall_d;

    always_comb begin
        perf_vec_d    = perf_vec_q;
        perf_xstall_d = perf_xstall_q;
        perf_wstall_d = perf_wstall_q;
        if (x_fire && (perf_vec_q != '1)) begin
            perf_vec_d = perf_vec_q + 1'b1;
        end
        if (x_valid && !x_ready && (perf_xstall_q != '1)) begin
            perf_xstall_d = perf_xstall_q + 1'b1;
        end
        if (w_valid && !w_ready && (perf_wstall_q != '1)) begin
            perf_wstall_d = perf_wstall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_vec_q    <= '0;
            perf_xstall_q <= '0;
            perf_wstall_q <= '0;
        end else begin
            perf_vec_q    <= perf_vec_d;
            perf_xstall_q <= perf_xstall_d;
            perf_wstall_q <= perf_wstall_d;
        end
    end

    assign perf_vec    = perf_vec_q;
    assign perf_xstall = perf_xstall_q;
    assign perf_wstall = perf_wstall_q;
`endif

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Directed-plus-random bench for sa_edge_feeder against a queue-based model of loaded weight sets.
module tb_sa_edge_feeder;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int DRAIN = 2 * N;

    logic           clk;
    logic           rst_n;
    logic           w_valid;
    logic           w_ready;
    logic [N*W-1:0] w_data;
    logic           x_valid;
    logic           x_ready;
    logic [N*W-1:0] x_data;
    logic           x_last;
    logic [N*W-1:0] b_data;
    logic [N-1:0]   b_slot;
    logic [N-1:0]   b_val;
    logic [N*W-1:0] a_data;
    logic [N-1:0]   a_slot;
    logic [N-1:0]   a_val;

    sa_edge_feeder #(.WIDTH(W), .N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_data  (x_data),
        .x_last  (x_last),
        .b_data  (b_data),
        .b_slot  (b_slot),
        .b_val   (b_val),
        .a_data  (a_data),
        .a_slot  (a_slot),
        .a_val   (a_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_fail;
    int cyc;

    // Model: loaded weight sets queue up in load order; the head is the set being streamed.
    bit             sets [$];
    bit             load_ptr;
    int             beats;
    int             drain;
    logic [N*W-1:0] exp_bdata;
    logic [N-1:0]   exp_bslot;
    logic [N-1:0]   exp_bval;
    logic [N*W-1:0] ring_data [8];
    logic [N-1:0]   ring_val  [8];
    logic [N-1:0]   ring_slot [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        sets.delete();
        load_ptr  = 1'b0;
        beats     = 0;
        drain     = 0;
        exp_bdata = '0;
        exp_bslot = '0;
        exp_bval  = '0;
        for (int i = 0; i < 8; i++) begin
            ring_data[i] = '0;
            ring_val[i]  = '0;
            ring_slot[i] = '0;
        end
    endtask

    task automatic drive(input logic wv, input logic [N*W-1:0] wd,
                         input logic xv, input logic [N*W-1:0] xd, input logic xl);
        w_valid = wv;
        w_data  = wd;
        x_valid = xv;
        x_data  = xd;
        x_last  = xl;
    endtask

    task automatic cycle();
        bit ew, ex, wf, xf;
        int k;
        ew = (sets.size() < 2) && (drain == 0);
        ex = (sets.size() > 0);
        check("w_ready", 32'(w_ready), 32'(ew));
        check("x_ready", 32'(x_ready), 32'(ex));
        wf = w_valid && ew;
        xf = x_valid && ex;
        if (xf) begin
            for (int r = 0; r < N; r++) begin
                k = (cyc + r + 1) % 8;
                ring_val[k][r]          = 1'b1;
                ring_data[k][r*W +: W]  = x_data[r*W +: W];
                ring_slot[k][r]         = sets[0];
            end
        end
        if (xf && x_last) begin
            void'(sets.pop_front());
            drain = DRAIN;
        end else if (drain > 0) begin
            drain--;
        end
        exp_bval = '0;
        if (wf) begin
            exp_bval  = '1;
            exp_bdata = w_data;
            exp_bslot = {N{load_ptr}};
            beats++;
            if (beats == N) begin
                sets.push_back(load_ptr);
                load_ptr = ~load_ptr;
                beats    = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        k = cyc % 8;
        check("b_val",  32'(b_val),  32'(exp_bval));
        check("b_data", 32'(b_data), 32'(exp_bdata));
        check("b_slot", 32'(b_slot), 32'(exp_bslot));
        check("a_val",  32'(a_val),  32'(ring_val[k]));
        check("a_data", 32'(a_data), 32'(ring_data[k]));
        check("a_slot", 32'(a_slot), 32'(ring_slot[k]));
        ring_val[k]  = '0;
        ring_data[k] = '0;
        ring_slot[k] = '0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check("rst_b_val",  32'(b_val),  32'd0);
        check("rst_b_data", 32'(b_data), 32'd0);
        check("rst_a_val",  32'(a_val),  32'd0);
        check("rst_a_data", 32'(a_data), 32'd0);
    endtask

    task automatic run(input int n, input bit wv, input bit xv, input bit xl);
        for (int i = 0; i < n; i++) begin
            drive(wv, N*W'($urandom), xv, N*W'($urandom), xl);
            cycle();
        end
    endtask

    initial begin
        logic [N*W-1:0] rows [4];
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        model_clear();
        @(negedge clk);

        // 1: reset then idle
        reset_dut();
        run(20, 1'b0, 1'b0, 1'b0);

        // 2: fixed weight set, one vector with x_last
        rows[0] = 16'h4444;
        rows[1] = 16'h3333;
        rows[2] = 16'h2222;
        rows[3] = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rows[i], 1'b0, '0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b1, 16'h4321, 1'b1);
        cycle();
        run(12, 1'b0, 1'b0, 1'b0);

        // 3: double buffering, final beat coincides with x_last, next vector has no bubble
        run(N, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            drive(1'b1, N*W'($urandom), (i > 0), N*W'($urandom), (i == N - 1));
            cycle();
        end
        check("no_bubble_x_ready", 32'(x_ready), 32'd1);
        drive(1'b0, '0, 1'b1, N*W'($urandom), 1'b0);
        cycle();
        run(10, 1'b0, 1'b0, 1'b0);

        // 4: both banks full with w_valid held, then release and drain
        run(N + 6, 1'b1, 1'b0, 1'b0);
        check("both_full_w_ready", 32'(w_ready), 32'd0);
        drive(1'b1, N*W'($urandom), 1'b1, N*W'($urandom), 1'b1);
        cycle();
        run(DRAIN + N + 2, 1'b1, 1'b0, 1'b0);

        // 5: gapped beats, four accepted over nine cycles
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            drive((i % 2) == 1, N*W'($urandom), 1'b1, N*W'($urandom), 1'b0);
            cycle();
        end
        run(3, 1'b0, 1'b1, 1'b1);

        // 6: reset after two beats discards the partial load
        reset_dut();
        run(2, 1'b1, 1'b0, 1'b0);
        reset_dut();
        run(3, 1'b1, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1, 1'b0);
        run(1, 1'b1, 1'b0, 1'b0);
        check("fresh_load_x_ready", 32'(x_ready), 32'd1);
        run(2, 1'b0, 1'b1, 1'b1);

        // 7: random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), N*W'($urandom),
                  1'($urandom_range(0, 1)), N*W'($urandom),
                  ($urandom_range(0, 3) == 0));
            cycle();
        end
        run(8, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
